// File: rtl/scroll_addr_gen_if.sv
// Scan-position, scroll-command and RAM-address signals between the VGA timing
// path and the scroll address generator.
interface scroll_addr_gen_if;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid;
    logic        cmd_valid;
    logic [1:0]  cmd_dir;
    logic        auto_en;
    logic [1:0]  auto_dir;
    logic [16:0] pixel_addr;
    logic        pix_valid;
    logic [8:0]  x_off;
    logic [7:0]  y_off;
    logic        frame_tick;

    modport master (
        output h_cnt, v_cnt, valid, cmd_valid, cmd_dir, auto_en, auto_dir,
        input  pixel_addr, pix_valid, x_off, y_off, frame_tick
    );

    modport slave (
        input  h_cnt, v_cnt, valid, cmd_valid, cmd_dir, auto_en, auto_dir,
        output pixel_addr, pix_valid, x_off, y_off, frame_tick
    );
endinterface

// File: rtl/scroll_addr_gen.sv
// Maps the 640x480 scan onto a 2x-doubled 320x240 image with wrap-around X/Y
// scrolling; offsets move only at the vertical-blanking frame tick.
module scroll_addr_gen #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int H_ACT    = 640,
    parameter int V_ACT    = 480,
    parameter int STEP     = 1,
    parameter int BRAM_LAT = 1
) (
    input logic              clk,
    input logic              rst,
    scroll_addr_gen_if.slave bus
);
    localparam int          DLY     = 1 + BRAM_LAT;
    localparam logic [9:0]  IMG_W_C = 10'(IMG_W);
    localparam logic [9:0]  IMG_H_C = 10'(IMG_H);
    localparam logic [9:0]  V_ACT_C = 10'(V_ACT);
    localparam logic [9:0]  STEP_C  = 10'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [1:0]       pend_dir_r, pend_dir_nxt_s;
    logic             rearm_r, rearm_nxt_s;
    logic             move_en_s;
    logic [1:0]       move_dir_s;
    logic [8:0]       x_off_r;
    logic [7:0]       y_off_r;
    logic             frame_tick_r;
    logic [16:0]      pixel_addr_r;
    logic [DLY-1:0]   vdly_r;
    logic [9:0]       x_sum_s, y_sum_s, x_s, y_s;
    logic [16:0]      addr_s;

    // Modular +/-STEP; one spare bit keeps the decrement from underflowing.
    function automatic logic [9:0] wrap_step(input logic [9:0] off,
                                             input logic       dec,
                                             input logic [9:0] dim);
        logic [9:0] r;
        if (dec) begin
            if (off < STEP_C) r = off + dim - STEP_C;
            else              r = off - STEP_C;
        end else begin
            r = off + STEP_C;
            if (r >= dim) r = r - dim;
        end
        return r;
    endfunction

    // Wrapped image coordinates and row-major address (y*320 as two shifts).
    always_comb begin
        x_sum_s = {1'b0, bus.h_cnt[9:1]} + {1'b0, x_off_r};
        y_sum_s = {1'b0, bus.v_cnt[9:1]} + {2'b00, y_off_r};
        if (x_sum_s >= IMG_W_C) x_s = x_sum_s - IMG_W_C;
        else                    x_s = x_sum_s;
        if (y_sum_s >= IMG_H_C) y_s = y_sum_s - IMG_H_C;
        else                    y_s = y_sum_s;
        addr_s = ({7'd0, y_s} << 8) + ({7'd0, y_s} << 6) + {7'd0, x_s};
    end

    // Address register, blanking-zeroed, plus the valid alignment delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr_r <= 17'd0;
            vdly_r       <= '0;
            frame_tick_r <= 1'b0;
        end else begin
            pixel_addr_r <= bus.valid ? addr_s : 17'd0;
            vdly_r       <= (vdly_r << 1) | DLY'(bus.valid);
            frame_tick_r <= (bus.v_cnt == V_ACT_C) && (bus.h_cnt == 10'd0);
        end
    end

    // Command FSM: a command seen on the tick cycle is kept for the next frame
    // (rearm), while the move on this tick uses the older pending direction.
    always_comb begin
        state_nxt_s    = state_r;
        pend_dir_nxt_s = pend_dir_r;
        rearm_nxt_s    = 1'b0;
        move_en_s      = 1'b0;
        move_dir_s     = pend_dir_r;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt_s    = ARMED;
                    pend_dir_nxt_s = bus.cmd_dir;
                end else begin
                    state_nxt_s    = IDLE;
                end
                if (frame_tick_r && bus.auto_en) begin
                    move_en_s  = 1'b1;
                    move_dir_s = bus.auto_dir;
                end else begin
                    move_en_s  = 1'b0;
                end
            end
            ARMED: begin
                if (frame_tick_r) begin
                    move_en_s   = 1'b1;
                    state_nxt_s = APPLY;
                end else begin
                    state_nxt_s = ARMED;
                end
                if (bus.cmd_valid) begin
                    pend_dir_nxt_s = bus.cmd_dir;
                    rearm_nxt_s    = frame_tick_r;
                end else begin
                    rearm_nxt_s    = 1'b0;
                end
            end
            APPLY: begin
                if (bus.cmd_valid) begin
                    state_nxt_s    = ARMED;
                    pend_dir_nxt_s = bus.cmd_dir;
                end else if (rearm_r) begin
                    state_nxt_s    = ARMED;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, pending direction and the scroll offsets.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pend_dir_r <= 2'b00;
            rearm_r    <= 1'b0;
            x_off_r    <= 9'd0;
            y_off_r    <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            pend_dir_r <= pend_dir_nxt_s;
            rearm_r    <= rearm_nxt_s;
            if (move_en_s) begin
                if (move_dir_s[1]) begin
                    y_off_r <= 8'(wrap_step({2'b00, y_off_r}, move_dir_s[0], IMG_H_C));
                end else begin
                    x_off_r <= 9'(wrap_step({1'b0, x_off_r}, move_dir_s[0], IMG_W_C));
                end
            end
        end
    end

    assign bus.pixel_addr = pixel_addr_r;
    assign bus.pix_valid  = vdly_r[DLY-1];
    assign bus.x_off      = x_off_r;
    assign bus.y_off      = y_off_r;
    assign bus.frame_tick = frame_tick_r;
endmodule

// File: tb/tb_scroll_addr_gen.sv
// Directed bench for scroll_addr_gen: addressing, wrap, command FSM, auto-scroll
// and reset behaviour with hand-computed expectations.
module tb_scroll_addr_gen;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    scroll_addr_gen_if bus ();

    scroll_addr_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = d;
        clk_step();
        bus.cmd_valid = 1'b0;
    endtask

    // Tick cycle, then one more edge so the offset move is visible on return.
    task automatic frame_edge();
        bus.valid = 1'b0;
        bus.v_cnt = 10'd480;
        bus.h_cnt = 10'd0;
        clk_step();
        bus.h_cnt = 10'd1;
        clk_step();
        bus.v_cnt = 10'd0;
        bus.h_cnt = 10'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid = 1'b1; bus.h_cnt = 10'd10; bus.v_cnt = 10'd6;
        clk_step(); clk_step();
        total++; if (bus.pixel_addr !== 17'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.pixel_addr); end
        total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL reset_pv got=%0b exp=0", bus.pix_valid); end
        total++; if (bus.x_off !== 9'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", bus.x_off); end
        total++; if (bus.y_off !== 8'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", bus.y_off); end
        total++; if (bus.frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%0b exp=0", bus.frame_tick); end
        bus.valid = 1'b0;
        rst = 1'b0;
        clk_step(); clk_step();
    endtask

    task automatic test_no_scroll();
        bus.valid = 1'b1; bus.h_cnt = 10'd10; bus.v_cnt = 10'd6;
        clk_step();
        total++; if (bus.pixel_addr !== 17'd965) begin bad++; $display("FAIL noscroll_addr got=%0d exp=965", bus.pixel_addr); end
        total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL pv_lat1 got=%0b exp=0", bus.pix_valid); end
        clk_step();
        total++; if (bus.pix_valid !== 1'b1) begin bad++; $display("FAIL pv_lat2 got=%0b exp=1", bus.pix_valid); end
        bus.h_cnt = 10'd639; bus.v_cnt = 10'd479;
        clk_step();
        total++; if (bus.pixel_addr !== 17'd76799) begin bad++; $display("FAIL last_pixel got=%0d exp=76799", bus.pixel_addr); end
        bus.valid = 1'b0;
        clk_step();
        total++; if (bus.pixel_addr !== 17'd0) begin bad++; $display("FAIL blank_addr got=%0d exp=0", bus.pixel_addr); end
    endtask

    task automatic test_frame_tick();
        bus.v_cnt = 10'd480; bus.h_cnt = 10'd0;
        clk_step();
        total++; if (bus.frame_tick !== 1'b1) begin bad++; $display("FAIL tick_high got=%0b exp=1", bus.frame_tick); end
        bus.h_cnt = 10'd1;
        clk_step();
        total++; if (bus.frame_tick !== 1'b0) begin bad++; $display("FAIL tick_pulse got=%0b exp=0", bus.frame_tick); end
        bus.v_cnt = 10'd0; bus.h_cnt = 10'd0;
        clk_step();
    endtask

    task automatic test_left_wrap();
        send_cmd(2'b01);
        bus.v_cnt = 10'd480; bus.h_cnt = 10'd0;
        clk_step();
        total++; if (bus.x_off !== 9'd0) begin bad++; $display("FAIL x_before_move got=%0d exp=0", bus.x_off); end
        bus.h_cnt = 10'd1;
        clk_step();
        total++; if (bus.x_off !== 9'd319) begin bad++; $display("FAIL left_wrap got=%0d exp=319", bus.x_off); end
        bus.valid = 1'b1; bus.h_cnt = 10'd2; bus.v_cnt = 10'd0;
        clk_step();
        total++; if (bus.pixel_addr !== 17'd0) begin bad++; $display("FAIL lw_addr_h2 got=%0d exp=0", bus.pixel_addr); end
        bus.h_cnt = 10'd0;
        clk_step();
        total++; if (bus.pixel_addr !== 17'd319) begin bad++; $display("FAIL lw_addr_h0 got=%0d exp=319", bus.pixel_addr); end
        send_cmd(2'b00);
        frame_edge();
        total++; if (bus.x_off !== 9'd0) begin bad++; $display("FAIL right_wrap got=%0d exp=0", bus.x_off); end
    endtask

    task automatic test_vertical();
        send_cmd(2'b11);
        frame_edge();
        total++; if (bus.y_off !== 8'd239) begin bad++; $display("FAIL down_wrap got=%0d exp=239", bus.y_off); end
        send_cmd(2'b10);
        frame_edge();
        total++; if (bus.y_off !== 8'd0) begin bad++; $display("FAIL up_wrap got=%0d exp=0", bus.y_off); end
        send_cmd(2'b10);
        frame_edge();
        total++; if (bus.y_off !== 8'd1) begin bad++; $display("FAIL y_plus got=%0d exp=1", bus.y_off); end
        bus.valid = 1'b1; bus.v_cnt = 10'd478; bus.h_cnt = 10'd0;
        clk_step();
        total++; if (bus.pixel_addr !== 17'd0) begin bad++; $display("FAIL y_wrap_addr got=%0d exp=0", bus.pixel_addr); end
        bus.v_cnt = 10'd0; bus.h_cnt = 10'd20;
        clk_step();
        total++; if (bus.pixel_addr !== 17'd330) begin bad++; $display("FAIL y1_addr got=%0d exp=330", bus.pixel_addr); end
        send_cmd(2'b11);
        frame_edge();
        total++; if (bus.y_off !== 8'd0) begin bad++; $display("FAIL y_restore got=%0d exp=0", bus.y_off); end
    endtask

    task automatic test_last_wins();
        send_cmd(2'b00);
        clk_step();
        send_cmd(2'b10);
        frame_edge();
        total++; if (bus.x_off !== 9'd0) begin bad++; $display("FAIL lastwin_x got=%0d exp=0", bus.x_off); end
        total++; if (bus.y_off !== 8'd1) begin bad++; $display("FAIL lastwin_y got=%0d exp=1", bus.y_off); end
        clk_step(); clk_step();
        // command on the tick cycle from IDLE: held for the following frame
        bus.v_cnt = 10'd480; bus.h_cnt = 10'd0;
        clk_step();
        bus.cmd_valid = 1'b1; bus.cmd_dir = 2'b00; bus.h_cnt = 10'd1;
        clk_step();
        bus.cmd_valid = 1'b0; bus.v_cnt = 10'd0; bus.h_cnt = 10'd0;
        total++; if (bus.x_off !== 9'd0) begin bad++; $display("FAIL coll_idle_now got=%0d exp=0", bus.x_off); end
        frame_edge();
        total++; if (bus.x_off !== 9'd1) begin bad++; $display("FAIL coll_idle_next got=%0d exp=1", bus.x_off); end
        // command on the tick cycle while ARMED: old move now, new move next frame
        send_cmd(2'b10);
        bus.v_cnt = 10'd480; bus.h_cnt = 10'd0;
        clk_step();
        bus.cmd_valid = 1'b1; bus.cmd_dir = 2'b00; bus.h_cnt = 10'd1;
        clk_step();
        bus.cmd_valid = 1'b0; bus.v_cnt = 10'd0; bus.h_cnt = 10'd0;
        total++; if (bus.y_off !== 8'd2) begin bad++; $display("FAIL coll_arm_y got=%0d exp=2", bus.y_off); end
        total++; if (bus.x_off !== 9'd1) begin bad++; $display("FAIL coll_arm_x got=%0d exp=1", bus.x_off); end
        clk_step();
        frame_edge();
        total++; if (bus.x_off !== 9'd2) begin bad++; $display("FAIL coll_arm_next got=%0d exp=2", bus.x_off); end
        send_cmd(2'b01); frame_edge();
        send_cmd(2'b01); frame_edge();
        send_cmd(2'b11); frame_edge();
        send_cmd(2'b11); frame_edge();
        total++; if ({bus.x_off, bus.y_off} !== 17'd0) begin bad++; $display("FAIL lw_restore got=%0d/%0d exp=0/0", bus.x_off, bus.y_off); end
    endtask

    task automatic test_auto();
        int auto_bad;
        auto_bad = 0;
        bus.auto_en = 1'b1; bus.auto_dir = 2'b00;
        for (int i = 1; i <= 320; i++) begin
            frame_edge();
            total++;
            if (bus.x_off !== 9'(i % 320)) begin
                bad++;
                if (auto_bad < 5) $display("FAIL auto_step frame=%0d got=%0d exp=%0d", i, bus.x_off, i % 320);
                auto_bad++;
            end
        end
        send_cmd(2'b10);
        frame_edge();
        total++; if (bus.x_off !== 9'd0) begin bad++; $display("FAIL preempt_x got=%0d exp=0", bus.x_off); end
        total++; if (bus.y_off !== 8'd1) begin bad++; $display("FAIL preempt_y got=%0d exp=1", bus.y_off); end
        frame_edge();
        total++; if (bus.x_off !== 9'd1) begin bad++; $display("FAIL auto_resume got=%0d exp=1", bus.x_off); end
        bus.auto_en = 1'b0;
        frame_edge();
        total++; if (bus.x_off !== 9'd1) begin bad++; $display("FAIL auto_off got=%0d exp=1", bus.x_off); end
        send_cmd(2'b01); frame_edge();
        send_cmd(2'b11); frame_edge();
    endtask

    task automatic test_blank_reset();
        for (int i = 0; i < 5; i++) begin
            send_cmd(2'b00);
            frame_edge();
        end
        total++; if (bus.x_off !== 9'd5) begin bad++; $display("FAIL x_five got=%0d exp=5", bus.x_off); end
        send_cmd(2'b00);
        rst = 1'b1; bus.valid = 1'b1; bus.h_cnt = 10'd10; bus.v_cnt = 10'd6;
        clk_step();
        total++; if (bus.x_off !== 9'd0) begin bad++; $display("FAIL rst_x got=%0d exp=0", bus.x_off); end
        total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL rst_pv got=%0b exp=0", bus.pix_valid); end
        rst = 1'b0;
        clk_step();
        total++; if (bus.pixel_addr !== 17'd965) begin bad++; $display("FAIL post_rst_addr got=%0d exp=965", bus.pixel_addr); end
        total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL refill1 got=%0b exp=0", bus.pix_valid); end
        clk_step();
        total++; if (bus.pix_valid !== 1'b1) begin bad++; $display("FAIL refill2 got=%0b exp=1", bus.pix_valid); end
        frame_edge();
        total++; if (bus.x_off !== 9'd0) begin bad++; $display("FAIL rst_discard got=%0d exp=0", bus.x_off); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        bus.h_cnt = 10'd0; bus.v_cnt = 10'd0; bus.valid = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_dir = 2'b00;
        bus.auto_en = 1'b0; bus.auto_dir = 2'b00;
        test_reset();
        test_no_scroll();
        test_frame_tick();
        test_left_wrap();
        test_vertical();
        test_last_wins();
        test_auto();
        test_blank_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
